// File: rtl/mesi_snoop_bus.sv
// Shared MESI snoop bus: round-robin arbitration, snoop broadcast, response
// collection and write-back / memory sequencing for one transaction at a time.
module mesi_snoop_bus #(
  parameter int unsigned NUM_CACHES = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CACHES-1:0]        req_valid,
  input  logic [2*NUM_CACHES-1:0]      req_type,
  input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
  output logic [NUM_CACHES-1:0]        grant,
  output logic [NUM_CACHES-1:0]        done,
  output logic                         done_shared,
  output logic [NUM_CACHES-1:0]        snoop_read,
  output logic [NUM_CACHES-1:0]        snoop_read_excl,
  output logic [NUM_CACHES-1:0]        snoop_invalidate,
  output logic [ADDR_W-1:0]            snoop_addr,
  input  logic [NUM_CACHES-1:0]        snoop_hit,
  input  logic [NUM_CACHES-1:0]        snoop_dirty,
  output logic                         mem_req_valid,
  output logic                         mem_req_we,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid
);

  localparam int unsigned ID_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

  localparam logic [1:0] BUS_RD   = 2'd0;
  localparam logic [1:0] BUS_RDX  = 2'd1;
  localparam logic [1:0] BUS_UPGR = 2'd2;
  localparam logic [1:0] FLUSH    = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNOOP  = 3'd1,
    WB     = 3'd2,
    MEM_RD = 3'd3,
    RESP   = 3'd4,
    MEM_WR = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     ptr, ptr_d, id, id_d, win;
  logic [1:0]          typ, typ_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic                shared, shared_d, dirty, dirty_d;
  logic                win_found, mem_valid_d;
  logic [NUM_CACHES-1:0] others;

  // Round-robin search upward from ptr+1 with wrap.
  always_comb begin
    int unsigned idx;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_CACHES; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_CACHES) idx = idx - NUM_CACHES;
      if (!win_found && req_valid[ID_W'(idx)]) begin
        win       = ID_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  // Every cache except the current requester.
  always_comb begin
    others     = '1;
    others[id] = 1'b0;
  end

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    id_d     = id;
    typ_d    = typ;
    addr_d   = addr;
    shared_d = shared;
    dirty_d  = dirty;
    case (state)
      IDLE: begin
        if (win_found) begin
          id_d     = win;
          ptr_d    = win;
          typ_d    = req_type[32'(win)*2 +: 2];
          addr_d   = req_addr[32'(win)*ADDR_W +: ADDR_W];
          shared_d = 1'b0;
          dirty_d  = 1'b0;
          state_d  = (typ_d == FLUSH) ? MEM_WR : SNOOP;
        end
      end
      SNOOP: begin
        shared_d = |(snoop_hit & others);
        dirty_d  = |(snoop_dirty & others);
        if (dirty_d)               state_d = WB;
        else if (typ == BUS_UPGR)  state_d = DONE;
        else                       state_d = MEM_RD;
      end
      WB: begin
        if (mem_req_ready) state_d = (typ == BUS_UPGR) ? DONE : MEM_RD;
      end
      MEM_RD: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) state_d = DONE;
      end
      MEM_WR: begin
        if (mem_req_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_valid_d = (state_d == WB) || (state_d == MEM_RD) || (state_d == MEM_WR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= ID_W'(NUM_CACHES - 1);
      id            <= '0;
      typ           <= '0;
      addr          <= '0;
      shared        <= 1'b0;
      dirty         <= 1'b0;
      done_shared   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      state         <= state_d;
      ptr           <= ptr_d;
      id            <= id_d;
      typ           <= typ_d;
      addr          <= addr_d;
      shared        <= shared_d;
      dirty         <= dirty_d;
      done_shared   <= (state_d == DONE) && shared_d;
      mem_req_valid <= mem_valid_d;
      mem_req_we    <= (state_d == WB) || (state_d == MEM_WR);
      mem_req_addr  <= mem_valid_d ? addr_d : '0;
    end
  end

  // Grant is decided in IDLE and suppressed while reset is held.
  assign grant = (state == IDLE && win_found && rst) ? (NUM_CACHES'(1) << win) : '0;
  assign done  = (state == DONE) ? (NUM_CACHES'(1) << id) : '0;

  assign snoop_read       = (state == SNOOP && typ == BUS_RD)   ? others : '0;
  assign snoop_read_excl  = (state == SNOOP && typ == BUS_RDX)  ? others : '0;
  assign snoop_invalidate = (state == SNOOP && typ == BUS_UPGR) ? others : '0;
  assign snoop_addr       = addr;

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Directed bench for mesi_snoop_bus: scoreboard queues for grants, memory
// requests and completions, checked every cycle on the falling edge.
module tb_mesi_snoop_bus;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;

  localparam logic [1:0] RD   = 2'd0;
  localparam logic [1:0] RDX  = 2'd1;
  localparam logic [1:0] UPGR = 2'd2;
  localparam logic [1:0] FL   = 2'd3;

  typedef struct packed { logic we; logic [AW-1:0] addr; } mem_t;
  typedef struct packed { logic [N-1:0] vec; logic shared; } done_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_type;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]    grant, done, snoop_read, snoop_read_excl, snoop_invalidate;
  logic            done_shared;
  logic [AW-1:0]   snoop_addr, mem_req_addr;
  logic [N-1:0]    snoop_hit, snoop_dirty;
  logic            mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;

  mesi_snoop_bus #(.NUM_CACHES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .grant(grant), .done(done), .done_shared(done_shared),
    .snoop_read(snoop_read), .snoop_read_excl(snoop_read_excl),
    .snoop_invalidate(snoop_invalidate), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, grant_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic busy = 1'b0, mem_auto = 1'b1, force_resp = 1'b0;

  mem_t         exp_mem[$];
  done_t        exp_done[$];
  logic [N-1:0] exp_grant[$];

  logic [N-1:0]  o_grant, o_sr, o_srx, o_si;
  logic [AW-1:0] o_saddr;
  logic          o_mv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mem_t mk_mem(input logic we, input logic [AW-1:0] a);
    mem_t m;
    m.we = we; m.addr = a;
    return m;
  endfunction

  function automatic done_t mk_done(input logic [N-1:0] v, input logic s);
    done_t d;
    d.vec = v; d.shared = s;
    return d;
  endfunction

  // One clock: sample and score on the falling edge, then drive memory response.
  task automatic tick();
    logic fire;
    done_t d;
    @(negedge clk);
    cyc++;
    o_grant = grant; o_sr = snoop_read; o_srx = snoop_read_excl;
    o_si = snoop_invalidate; o_saddr = snoop_addr; o_mv = mem_req_valid;
    fire = 1'b0;
    if (|grant) begin
      chk("grant_while_busy", 64'(busy), 64'(0));
      if (exp_grant.size() == 0) chk("grant_extra", 64'(grant), 64'(0));
      else chk("grant_order", 64'(grant), 64'(exp_grant.pop_front()));
      busy = 1'b1;
      grant_cyc = cyc;
    end
    if (mem_req_valid) begin
      if (exp_mem.size() == 0) chk("mem_extra", 64'(mem_req_valid), 64'(0));
      else begin
        chk("mem_we", 64'(mem_req_we), 64'(exp_mem[0].we));
        chk("mem_addr", 64'(mem_req_addr), 64'(exp_mem[0].addr));
        if (mem_req_ready) begin
          void'(exp_mem.pop_front());
          fire = !mem_req_we && mem_auto;
        end
      end
    end
    if (|done) begin
      busy = 1'b0;
      done_cnt++;
      done_cyc = cyc;
      if (exp_done.size() == 0) chk("done_extra", 64'(done), 64'(0));
      else begin
        d = exp_done.pop_front();
        chk("done_vec", 64'(done), 64'(d.vec));
        chk("done_shared", 64'(done_shared), 64'(d.shared));
      end
    end
    @(posedge clk);
    #1;
    mem_resp_valid = fire || force_resp;
  endtask

  task automatic request(input int c, input logic [1:0] t, input logic [AW-1:0] a);
    req_valid[c] = 1'b1;
    req_type[2*c +: 2] = t;
    req_addr[AW*c +: AW] = a;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (|o_grant) break;
    end
    chk("grant_timeout", 64'(|o_grant), 64'(1));
  endtask

  task automatic wait_done();
    int s;
    s = done_cnt;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done_cnt != s) break;
    end
    chk("done_timeout", 64'(done_cnt - s), 64'(1));
  endtask

  initial begin
    int g, s;
    rst = 1'b0;
    req_valid = '0; req_type = '0; req_addr = '0;
    snoop_hit = '0; snoop_dirty = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_outputs", 64'({grant, done, done_shared, snoop_read, snoop_read_excl,
                            snoop_invalidate, mem_req_valid, mem_req_we}), 64'(0));
    chk("rst_addrs", 64'({snoop_addr, mem_req_addr}), 64'(0));
    rst = 1'b1;
    tick();

    // Cache 1 BusRd, no hits
    exp_grant.push_back(4'b0010);
    exp_mem.push_back(mk_mem(1'b0, 32'h1000));
    exp_done.push_back(mk_done(4'b0010, 1'b0));
    request(1, RD, 32'h1000);
    wait_grant(); g = grant_cyc; req_valid[1] = 1'b0;
    tick();
    chk("rd_snoop_read", 64'(o_sr), 64'(4'b1101));
    chk("rd_other_snoops", 64'({o_srx, o_si}), 64'(0));
    chk("rd_snoop_addr", 64'(o_saddr), 64'(32'h1000));
    wait_done();
    chk("rd_latency", 64'(done_cyc - g), 64'(4));

    // Cache 0 BusRd with another cache holding the line
    snoop_hit = 4'b0100;
    exp_grant.push_back(4'b0001);
    exp_mem.push_back(mk_mem(1'b0, 32'h2000));
    exp_done.push_back(mk_done(4'b0001, 1'b1));
    request(0, RD, 32'h2000);
    wait_grant(); req_valid[0] = 1'b0;
    wait_done();

    // Cache 2 BusRdX, dirty without hit -> write-back then read
    snoop_hit = '0; snoop_dirty = 4'b0001;
    exp_grant.push_back(4'b0100);
    exp_mem.push_back(mk_mem(1'b1, 32'h40));
    exp_mem.push_back(mk_mem(1'b0, 32'h40));
    exp_done.push_back(mk_done(4'b0100, 1'b0));
    request(2, RDX, 32'h40);
    wait_grant(); req_valid[2] = 1'b0;
    tick();
    chk("rdx_snoop_excl", 64'(o_srx), 64'(4'b1011));
    wait_done();

    // Cache 1 BusUpgr with two dirty holders: single write-back
    snoop_hit = 4'b1001; snoop_dirty = 4'b1001;
    exp_grant.push_back(4'b0010);
    exp_mem.push_back(mk_mem(1'b1, 32'h600));
    exp_done.push_back(mk_done(4'b0010, 1'b1));
    request(1, UPGR, 32'h600);
    wait_grant(); req_valid[1] = 1'b0;
    wait_done();

    // Cache 3 BusUpgr; only its own (masked) responses set
    snoop_hit = 4'b1000; snoop_dirty = 4'b1000;
    exp_grant.push_back(4'b1000);
    exp_done.push_back(mk_done(4'b1000, 1'b0));
    request(3, UPGR, 32'h300);
    wait_grant(); g = grant_cyc; req_valid[3] = 1'b0;
    tick();
    chk("upgr_snoop_inv", 64'(o_si), 64'(4'b0111));
    chk("upgr_no_mem", 64'(o_mv), 64'(0));
    wait_done();
    chk("upgr_latency", 64'(done_cyc - g), 64'(2));
    snoop_hit = '0; snoop_dirty = '0;

    // All caches requesting: strict rotation, first transaction stalled
    for (int k = 0; k < 8; k++) begin
      exp_grant.push_back(4'b0001 << (k % 4));
      exp_mem.push_back(mk_mem(1'b0, 32'h8000 + 32'(k % 4) * 32'h100));
      exp_done.push_back(mk_done(4'b0001 << (k % 4), 1'b0));
    end
    for (int c = 0; c < 4; c++) request(c, RD, 32'h8000 + 32'(c) * 32'h100);
    for (int k = 0; k < 8; k++) begin
      wait_grant();
      if (k == 7) req_valid = '0;
      if (k == 0) begin
        mem_req_ready = 1'b0;
        tick();
        repeat (5) begin
          tick();
          chk("stall_valid", 64'(o_mv), 64'(1));
        end
        mem_req_ready = 1'b1;
      end
      wait_done();
    end

    // Cache 2 Flush: no snoops, write only, shared forced low
    snoop_hit = '1;
    exp_grant.push_back(4'b0100);
    exp_mem.push_back(mk_mem(1'b1, 32'h80));
    exp_done.push_back(mk_done(4'b0100, 1'b0));
    request(2, FL, 32'h80);
    wait_grant(); req_valid[2] = 1'b0;
    tick();
    chk("flush_no_snoop", 64'({o_sr, o_srx, o_si}), 64'(0));
    wait_done();
    snoop_hit = '0;

    // Reset while waiting in RESP
    mem_auto = 1'b0;
    exp_grant.push_back(4'b0010);
    exp_mem.push_back(mk_mem(1'b0, 32'h500));
    request(1, RD, 32'h500);
    wait_grant(); req_valid[1] = 1'b0;
    tick(); tick();
    #1;
    rst = 1'b0; busy = 1'b0;
    #1;
    chk("midrst_outputs", 64'({grant, done, done_shared, snoop_read, snoop_read_excl,
                               snoop_invalidate, mem_req_valid, mem_req_we}), 64'(0));
    chk("midrst_mem_addr", 64'(mem_req_addr), 64'(0));
    tick(); tick();
    rst = 1'b1;
    mem_auto = 1'b1;
    s = done_cnt;
    force_resp = 1'b1;
    tick();
    force_resp = 1'b0;
    tick(); tick();
    chk("stray_resp_ignored", 64'(done_cnt - s), 64'(0));
    chk("stray_resp_no_mem", 64'(o_mv), 64'(0));

    // Pointer back at reset value: cache 0 beats cache 2
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0100);
    exp_mem.push_back(mk_mem(1'b0, 32'h700));
    exp_mem.push_back(mk_mem(1'b0, 32'h900));
    exp_done.push_back(mk_done(4'b0001, 1'b0));
    exp_done.push_back(mk_done(4'b0100, 1'b0));
    request(2, RD, 32'h900);
    request(0, RD, 32'h700);
    wait_grant(); req_valid[0] = 1'b0;
    wait_done();
    wait_grant(); req_valid[2] = 1'b0;
    wait_done();
    tick();

    chk("queues_drained", 64'(exp_grant.size() + exp_mem.size() + exp_done.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
